// File: rtl/axi_aw_beat_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : axi_aw_beat_gen_if
// Brief   : AW request and per-beat address bundle between requester and beat generator.
// Revision: 1.0
// ============================================================================
interface axi_aw_beat_gen_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] aw_addr;
   logic [7:0]        aw_len;
   logic [2:0]        aw_size;
   logic [1:0]        aw_burst;
   logic              aw_valid;
   logic              aw_ready;
   logic [ADDR_W-1:0] beat_addr;
   logic [7:0]        beat_idx;
   logic              beat_last;
   logic              beat_valid;
   logic              beat_ready;
   logic              aw_err;

   modport master (
      output aw_addr, aw_len, aw_size, aw_burst, aw_valid, beat_ready,
      input  aw_ready, beat_addr, beat_idx, beat_last, beat_valid, aw_err
   );

   modport slave (
      input  aw_addr, aw_len, aw_size, aw_burst, aw_valid, beat_ready,
      output aw_ready, beat_addr, beat_idx, beat_last, beat_valid, aw_err
   );
endinterface
`default_nettype wire

// File: rtl/axi_aw_beat_gen.sv
`default_nettype none
// ============================================================================
// Module  : axi_aw_beat_gen
// Brief   : Expands one AW burst request into per-beat addresses (FIXED/INCR/WRAP).
// Revision: 1.0
// ============================================================================
module axi_aw_beat_gen #(
   parameter int ADDR_W   = 32,
   parameter int MAX_SIZE = 2
) (
   input  wire logic          clk,
   input  wire logic          reset,
   axi_aw_beat_gen_if.slave   bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_ERR   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        idx_q, idx_d;
   logic [7:0]        len_q, len_d;
   logic [2:0]        size_q, size_d;
   logic [1:0]        burst_q, burst_d;
   logic              aw_ready_q, aw_ready_d;

   // request legality, evaluated on the incoming AW fields
   logic [ADDR_W-1:0] w_b_in;
   logic              w_misaligned;
   logic              w_size_bad;
   logic              w_wrap_len_ok;
   logic              w_legal;

   assign w_b_in        = ADDR_W'(1) << bus.aw_size;
   assign w_misaligned  = |(bus.aw_addr & (w_b_in - ADDR_W'(1)));
   assign w_size_bad    = bus.aw_size > 3'(MAX_SIZE);
   assign w_wrap_len_ok = (bus.aw_len == 8'd1) || (bus.aw_len == 8'd3) ||
                          (bus.aw_len == 8'd7) || (bus.aw_len == 8'd15);
   assign w_legal       = (bus.aw_burst != 2'd3) && !w_size_bad &&
                          !((bus.aw_burst == 2'd2) && (!w_wrap_len_ok || w_misaligned));

   // next-beat address from the latched burst parameters
   logic [ADDR_W-1:0] w_b;
   logic [ADDR_W-1:0] w_t;
   logic [ADDR_W-1:0] w_lower;
   logic [ADDR_W-1:0] w_wnext;
   logic [ADDR_W-1:0] w_next_addr;
   logic              w_last;

   assign w_b     = ADDR_W'(1) << size_q;
   assign w_t     = w_b * (ADDR_W'(len_q) + ADDR_W'(1));
   assign w_lower = addr_q & ~(w_t - ADDR_W'(1));
   assign w_wnext = addr_q + w_b;
   assign w_last  = (idx_q == len_q);

   always_comb begin
      w_next_addr = addr_q;
      case (burst_q)
         2'd1:    w_next_addr = (addr_q & ~(w_b - ADDR_W'(1))) + w_b;
         2'd2:    w_next_addr = (w_wnext == (w_lower + w_t)) ? w_lower : w_wnext;
         default: w_next_addr = addr_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      len_d   = len_q;
      size_d  = size_q;
      burst_d = burst_q;
      case (state_q)
         S_IDLE: begin
            if (bus.aw_valid && aw_ready_q) begin
               addr_d  = bus.aw_addr;
               idx_d   = 8'd0;
               len_d   = bus.aw_len;
               size_d  = bus.aw_size;
               burst_d = bus.aw_burst;
               state_d = w_legal ? S_BURST : S_ERR;
            end
         end
         S_BURST: begin
            if (bus.beat_ready) begin
               if (w_last) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d  = idx_q + 8'd1;
                  addr_d = w_next_addr;
               end
            end
         end
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // registered so aw_ready stays low through reset and rises one edge after release
      aw_ready_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         idx_q      <= 8'd0;
         len_q      <= 8'd0;
         size_q     <= 3'd0;
         burst_q    <= 2'd0;
         aw_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         idx_q      <= idx_d;
         len_q      <= len_d;
         size_q     <= size_d;
         burst_q    <= burst_d;
         aw_ready_q <= aw_ready_d;
      end
   end

   assign bus.aw_ready   = aw_ready_q;
   assign bus.beat_valid = (state_q == S_BURST);
   assign bus.beat_addr  = addr_q;
   assign bus.beat_idx   = idx_q;
   assign bus.beat_last  = (state_q == S_BURST) && w_last;
   assign bus.aw_err     = (state_q == S_ERR);
endmodule
`default_nettype wire

// File: tb/tb_axi_aw_beat_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_aw_beat_gen
// Brief   : Scoreboard bench for axi_aw_beat_gen burst expansion and error handling.
// Revision: 1.0
// ============================================================================
module tb_axi_aw_beat_gen;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   axi_aw_beat_gen_if #(.ADDR_W(32)) bus ();

   axi_aw_beat_gen #(.ADDR_W(32), .MAX_SIZE(2)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  idx;
      logic        last;
   } beat_t;

   beat_t sb[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] exp_addr(input logic [31:0] s, input int len,
                                            input int size, input int burst, input int n);
      logic [31:0] b, t, lo, off;
      b = 32'd1 << size;
      if (burst == 0) return s;
      if (burst == 1) return (n == 0) ? s : (s & ~(b - 32'd1)) + 32'(n) * b;
      t   = b * 32'(len + 1);
      lo  = s & ~(t - 32'd1);
      off = ((s - lo) + 32'(n) * b) % t;
      return lo + off;
   endfunction

   function automatic bit is_legal(input logic [31:0] a, input int len, input int size, input int burst);
      if (burst == 3 || size > 2) return 1'b0;
      if (burst == 2) begin
         if (!(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
         if ((a & ((32'd1 << size) - 32'd1)) != 32'd0) return 1'b0;
      end
      return 1'b1;
   endfunction

   // monitor: pops expected beats on handshakes, checks stall stability
   bit          stall_seen = 1'b0;
   logic [31:0] st_addr;
   logic [7:0]  st_idx;
   beat_t       e;
   always @(negedge clk) begin
      if (reset) begin
         stall_seen = 1'b0;
      end else begin
         if (stall_seen) begin
            check_eq("stall_valid", 32'(bus.beat_valid), 32'd1);
            check_eq("stall_addr", bus.beat_addr, st_addr);
            check_eq("stall_idx", 32'(bus.beat_idx), 32'(st_idx));
         end
         stall_seen = 1'b0;
         if (bus.beat_valid) begin
            if (bus.beat_ready) begin
               if (sb.size() == 0) begin
                  check_eq("unexpected_beat", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check_eq("beat_addr", bus.beat_addr, e.addr);
                  check_eq("beat_idx", 32'(bus.beat_idx), 32'(e.idx));
                  check_eq("beat_last", 32'(bus.beat_last), 32'(e.last));
               end
            end else begin
               stall_seen = 1'b1;
               st_addr    = bus.beat_addr;
               st_idx     = bus.beat_idx;
            end
         end
      end
   end

   task automatic send(input logic [31:0] a, input int len, input int size, input int burst);
      bit ok;
      beat_t b;
      @(negedge clk);
      bus.aw_addr  = a;
      bus.aw_len   = 8'(len);
      bus.aw_size  = 3'(size);
      bus.aw_burst = 2'(burst);
      bus.aw_valid = 1'b1;
      if (is_legal(a, len, size, burst)) begin
         for (int n = 0; n <= len; n++) begin
            b.addr = exp_addr(a, len, size, burst, n);
            b.idx  = 8'(n);
            b.last = (n == len);
            sb.push_back(b);
         end
      end
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (bus.aw_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check_eq("aw_ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 bus.aw_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #2;
         if (sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      @(negedge clk);
      check_eq({tag, "_aw_ready_after"}, 32'(bus.aw_ready), 32'd1);
      check_eq({tag, "_valid_after"}, 32'(bus.beat_valid), 32'd0);
   endtask

   task automatic run_legal(input string tag, input logic [31:0] a, input int len,
                            input int size, input int burst);
      send(a, len, size, burst);
      @(negedge clk);
      check_eq({tag, "_latency"}, 32'(bus.beat_valid), 32'd1);
      wait_done(tag);
   endtask

   task automatic run_illegal(input string tag, input logic [31:0] a, input int len,
                              input int size, input int burst);
      send(a, len, size, burst);
      @(negedge clk);
      check_eq({tag, "_err"}, 32'(bus.aw_err), 32'd1);
      check_eq({tag, "_valid"}, 32'(bus.beat_valid), 32'd0);
      check_eq({tag, "_ready_low"}, 32'(bus.aw_ready), 32'd0);
      @(negedge clk);
      check_eq({tag, "_err_clear"}, 32'(bus.aw_err), 32'd0);
      check_eq({tag, "_ready_back"}, 32'(bus.aw_ready), 32'd1);
      check_eq({tag, "_valid2"}, 32'(bus.beat_valid), 32'd0);
   endtask

   initial begin
      reset          = 1'b1;
      bus.aw_addr    = '0;
      bus.aw_len     = '0;
      bus.aw_size    = '0;
      bus.aw_burst   = '0;
      bus.aw_valid   = 1'b0;
      bus.beat_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_aw_ready", 32'(bus.aw_ready), 32'd0);
      check_eq("rst_beat_valid", 32'(bus.beat_valid), 32'd0);
      check_eq("rst_aw_err", 32'(bus.aw_err), 32'd0);
      check_eq("rst_beat_addr", bus.beat_addr, 32'd0);
      check_eq("rst_beat_idx", 32'(bus.beat_idx), 32'd0);
      check_eq("rst_beat_last", 32'(bus.beat_last), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("rel_aw_ready_early", 32'(bus.aw_ready), 32'd0);
      @(negedge clk);
      check_eq("rel_aw_ready", 32'(bus.aw_ready), 32'd1);

      run_legal("incr", 32'h0000_1000, 3, 2, 1);
      run_legal("wrap", 32'h0000_1038, 3, 2, 2);
      run_legal("wrap8", 32'h0000_2016, 7, 1, 2);
      run_legal("len0", 32'h0000_5004, 0, 2, 1);
      run_legal("unal", 32'h0000_1003, 1, 2, 1);
      run_legal("top", 32'hFFFF_FFFC, 1, 2, 1);

      // FIXED burst with a three-cycle stall on beat 1
      send(32'h0000_2000, 2, 2, 0);
      @(posedge clk);
      #1 bus.beat_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_eq("stall_idx1", 32'(bus.beat_idx), 32'd1);
         check_eq("stall_valid1", 32'(bus.beat_valid), 32'd1);
      end
      @(posedge clk);
      #1 bus.beat_ready = 1'b1;
      wait_done("fixed");

      run_illegal("ill_burst3", 32'h0000_3000, 3, 2, 3);
      run_illegal("ill_wraplen", 32'h0000_3000, 2, 2, 2);
      run_illegal("ill_size3", 32'h0000_3000, 3, 3, 1);
      run_illegal("ill_wrapmis", 32'h0000_3002, 3, 2, 2);

      // reset in the middle of an 8-beat burst
      send(32'h0000_6000, 7, 2, 1);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      sb.delete();
      @(posedge clk);
      @(negedge clk);
      check_eq("mid_rst_valid", 32'(bus.beat_valid), 32'd0);
      check_eq("mid_rst_ready", 32'(bus.aw_ready), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_eq("mid_rel_ready_early", 32'(bus.aw_ready), 32'd0);
      @(negedge clk);
      check_eq("mid_rel_ready", 32'(bus.aw_ready), 32'd1);
      run_legal("after_rst", 32'h0000_7000, 1, 2, 1);

      repeat (3) @(negedge clk);
      check_eq("sb_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
